// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-serial load/store unit.
package lsu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int MAX_BEATS  = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Zero marks a funct3 that is not a load/store width.
   function automatic logic [2:0] beats_for(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: beats_for = 3'd1;
         F3_H, F3_HU: beats_for = 3'd2;
         F3_W:        beats_for = 3'd4;
         default:     beats_for = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response and byte-wide data-memory port.
interface lsu_if;
   import lsu_pkg::*;

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  is_store_i;
   logic [2:0]            funct3_i;
   logic [DATA_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  resp_valid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  err_o;
   logic                  busy_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_we_o;
   logic [2:0]            mem_funct3_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport master (
      output req_valid_i, is_store_i, funct3_i,
      output addr_i, wdata_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, rdata_o,
      input  err_o, busy_o, mem_addr_o,
      input  mem_wdata_o, mem_we_o, mem_funct3_o
   );

   modport slave (
      input  req_valid_i, is_store_i, funct3_i,
      input  addr_i, wdata_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, rdata_o,
      output err_o, busy_o, mem_addr_o,
      output mem_wdata_o, mem_we_o, mem_funct3_o
   );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load value by RV32I funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = '0;
      unique case (1'b1)
         (funct3 == F3_B):  ext = {{24{raw[7]}}, raw[7:0]};
         (funct3 == F3_H):  ext = {{16{raw[15]}}, raw[15:0]};
         (funct3 == F3_W):  ext = raw;
         (funct3 == F3_BU): ext = {24'd0, raw[7:0]};
         (funct3 == F3_HU): ext = {16'd0, raw[15:0]};
         default:           ext = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Splits RV32I loads/stores into sequential byte beats on a
// byte-only data memory and returns extended load data.
module load_store_unit (
   input logic  clk,
   input logic  rst,
   lsu_if.slave bus
);
   import lsu_pkg::*;

   state_t      state;
   logic [1:0]  beat;
   logic [2:0]  nbeats;
   logic [2:0]  f3;
   logic        store;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] asm_q;
   logic [31:0] rdata;
   logic        resp;
   logic        err;

   logic [2:0]  req_beats;
   logic        legal;
   logic        last;
   logic        in_access;
   logic        wr_beat;
   logic [7:0]  wbyte;
   logic [31:0] asm_next;
   logic [31:0] ext;
   logic        unused_rdata;

   assign req_beats = beats_for(bus.funct3_i);
   assign legal     = (req_beats != 3'd0) &&
                      !(bus.is_store_i && bus.funct3_i[2]);
   assign last      = ({1'b0, beat} == nbeats - 3'd1);
   assign in_access = (state == ACCESS);
   assign wr_beat   = in_access && store;
   assign wbyte     = wdata[{beat, 3'b000} +: 8];

   // Result as it will look once this beat's byte is captured.
   always_comb begin
      asm_next = asm_q;
      asm_next[{beat, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
   end

   load_extend u_ext (
      .funct3 (f3),
      .raw    (asm_next),
      .ext    (ext)
   );

   assign bus.req_ready_o  = (state == IDLE);
   assign bus.busy_o       = (state != IDLE);
   assign bus.resp_valid_o = resp;
   assign bus.err_o        = err;
   assign bus.rdata_o      = rdata;

   assign bus.mem_we_o     = wr_beat;
   assign bus.mem_addr_o   = in_access ?
                             base + {30'd0, beat} : '0;
   assign bus.mem_wdata_o  = wr_beat ? {24'd0, wbyte} : '0;
   assign bus.mem_funct3_o = wr_beat ? F3_B : F3_BU;

   assign unused_rdata = ^bus.mem_rdata_i[31:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         beat   <= 2'd0;
         nbeats <= 3'd0;
         f3     <= 3'd0;
         store  <= 1'b0;
         base   <= '0;
         wdata  <= '0;
         asm_q  <= '0;
         rdata  <= '0;
         resp   <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp <= 1'b0;
               err  <= 1'b0;
               if (bus.req_valid_i) begin
                  base   <= bus.addr_i;
                  wdata  <= bus.wdata_i;
                  f3     <= bus.funct3_i;
                  store  <= bus.is_store_i;
                  nbeats <= req_beats;
                  beat   <= 2'd0;
                  asm_q  <= '0;
                  if (legal) begin
                     state <= ACCESS;
                  end else begin
                     state <= DONE;
                     resp  <= 1'b1;
                     err   <= 1'b1;
                     rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               asm_q <= asm_next;
               beat  <= beat + 2'd1;
               if (last) begin
                  state <= DONE;
                  beat  <= 2'd0;
                  resp  <= 1'b1;
                  rdata <= store ? '0 : ext;
               end
            end
            DONE: begin
               state <= IDLE;
               resp  <= 1'b0;
               err   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               resp  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a
// byte-array memory model.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_if bus ();

   load_store_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory aliases on the low address byte; the model does the same.
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   logic       pre_we;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;

   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (bus.mem_we_o)
         mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o[7:0];
   end

   assign bus.mem_rdata_i = {24'h0, mem[bus.mem_addr_o[7:0]]};

   int n_tests;
   int n_fail;
   logic [31:0] rd;
   int          lat;
   logic        st;
   logic [2:0]  f3;
   logic [31:0] a;
   logic [31:0] wd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic int model_beats(input logic [2:0] f);
      case (f)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f,
                                              input logic [31:0] ad);
      int n;
      logic [31:0] v;
      n = model_beats(f);
      v = 32'd0;
      for (int k = 0; k < n; k++)
         v = v | (32'(ref_mem[8'(ad + 32'(k))]) << (8 * k));
      if (n == 1 && !f[2] && v[7])  v = v | 32'hFFFF_FF00;
      if (n == 2 && !f[2] && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic poke(input logic [31:0] ad, input logic [7:0] d);
      pre_addr = ad[7:0];
      pre_data = d;
      pre_we   = 1'b1;
      ref_mem[ad[7:0]] = d;
      @(posedge clk); #1;
      pre_we   = 1'b0;
   endtask

   task automatic idle_checks(input string tag);
      chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
      chk({tag, "_resp"}, 32'(bus.resp_valid_o), 32'd0);
      chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
      chk({tag, "_maddr"}, bus.mem_addr_o, 32'd0);
      chk({tag, "_mf3"}, 32'(bus.mem_funct3_o), 32'd4);
   endtask

   // Called #1 after a posedge with the DUT idle; returns likewise.
   task automatic access(input logic s, input logic [2:0] f,
                         input logic [31:0] ad, input logic [31:0] w,
                         input bit junk,
                         output logic [31:0] r, output int l);
      int n;
      bit ok;
      bit got;
      int nb;
      int cyc;
      logic [31:0] exp_rd;
      logic [31:0] ba  [8];
      logic        bwe [8];
      logic [31:0] bwd [8];
      logic [2:0]  bf3 [8];
      n  = model_beats(f);
      ok = (n != 0) && !(s && f[2]);
      exp_rd = (ok && !s) ? model_load(f, ad) : 32'd0;
      chk("ready_before", 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i = 1'b1;
      bus.is_store_i  = s;
      bus.funct3_i    = f;
      bus.addr_i      = ad;
      bus.wdata_i     = w;
      @(posedge clk); #1;
      // A request while busy must be ignored.
      bus.req_valid_i = junk;
      bus.is_store_i  = 1'($urandom);
      bus.funct3_i    = 3'($urandom);
      bus.addr_i      = $urandom;
      bus.wdata_i     = $urandom;
      cyc = 1;
      nb  = 0;
      got = 0;
      r   = 32'd0;
      l   = 0;
      while (!got && cyc <= 8) begin
         if (bus.resp_valid_o) begin
            got = 1;
            l   = cyc;
            r   = bus.rdata_o;
            chk("err", 32'(bus.err_o), 32'(!ok));
            bus.req_valid_i = 1'b0;
         end else begin
            if (nb < 8) begin
               ba[nb]  = bus.mem_addr_o;
               bwe[nb] = bus.mem_we_o;
               bwd[nb] = bus.mem_wdata_o;
               bf3[nb] = bus.mem_funct3_o;
            end
            nb++;
            @(posedge clk); #1;
            cyc++;
         end
      end
      bus.req_valid_i = 1'b0;
      chk("resp_seen", 32'(got), 32'd1);
      chk("latency", 32'(l), ok ? 32'(n + 1) : 32'd1);
      chk("beat_count", 32'(nb), ok ? 32'(n) : 32'd0);
      chk("rdata", r, exp_rd);
      if (ok) begin
         for (int k = 0; k < n && k < nb; k++) begin
            chk("beat_addr", ba[k], ad + 32'(k));
            chk("beat_we", 32'(bwe[k]), 32'(s));
            chk("beat_f3", 32'(bf3[k]), s ? 32'd0 : 32'd4);
            if (s) chk("beat_wdata", bwd[k], (w >> (8 * k)) & 32'hFF);
         end
         if (s)
            for (int k = 0; k < n; k++)
               ref_mem[8'(ad + 32'(k))] = 8'(w >> (8 * k));
      end
      if (got) begin
         @(posedge clk); #1;
         idle_checks("after");
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      pre_we = 1'b0;
      pre_addr = 8'd0;
      pre_data = 8'd0;
      bus.req_valid_i = 1'b0;
      bus.is_store_i  = 1'b0;
      bus.funct3_i    = 3'd0;
      bus.addr_i      = 32'd0;
      bus.wdata_i     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      idle_checks("reset");
      chk("reset_err", 32'(bus.err_o), 32'd0);
      chk("reset_rdata", bus.rdata_o, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 256; i++) poke(32'(i), 8'($urandom));

      // LW little-endian assembly
      poke(32'h10000, 8'h11);
      poke(32'h10001, 8'h22);
      poke(32'h10002, 8'h33);
      poke(32'h10003, 8'h44);
      access(1'b0, 3'b010, 32'h10000, 32'd0, 1'b0, rd, lat);
      chk("lw_value", rd, 32'h4433_2211);
      chk("lw_latency", 32'(lat), 32'd5);

      // Byte and halfword extension
      poke(32'h10010, 8'h80);
      access(1'b0, 3'b000, 32'h10010, 32'd0, 1'b1, rd, lat);
      chk("lb_value", rd, 32'hFFFF_FF80);
      chk("lb_latency", 32'(lat), 32'd2);
      access(1'b0, 3'b100, 32'h10010, 32'd0, 1'b0, rd, lat);
      chk("lbu_value", rd, 32'h0000_0080);
      poke(32'h10020, 8'h01);
      poke(32'h10021, 8'h80);
      access(1'b0, 3'b001, 32'h10020, 32'd0, 1'b0, rd, lat);
      chk("lh_value", rd, 32'hFFFF_8001);

      // Misaligned SH then LHU read-back
      access(1'b1, 3'b001, 32'h10001, 32'h0000_BEEF, 1'b1, rd, lat);
      chk("sh_rdata", rd, 32'd0);
      access(1'b0, 3'b101, 32'h10001, 32'd0, 1'b0, rd, lat);
      chk("lhu_value", rd, 32'h0000_BEEF);

      // Address wrap
      access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 1'b0, rd, lat);

      // Reset mid-store leaves the first two bytes written
      poke(32'h20, 8'h01);
      poke(32'h21, 8'h02);
      poke(32'h22, 8'h03);
      poke(32'h23, 8'h04);
      bus.req_valid_i = 1'b1;
      bus.is_store_i  = 1'b1;
      bus.funct3_i    = 3'b010;
      bus.addr_i      = 32'h20;
      bus.wdata_i     = 32'hDDCC_BBAA;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      chk("rst_b0_addr", bus.mem_addr_o, 32'h20);
      chk("rst_b0_data", bus.mem_wdata_o, 32'hAA);
      @(posedge clk); #1;
      chk("rst_b1_addr", bus.mem_addr_o, 32'h21);
      chk("rst_b1_data", bus.mem_wdata_o, 32'hBB);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle_checks("rst_mid");
      ref_mem[8'h20] = 8'hAA;
      ref_mem[8'h21] = 8'hBB;
      access(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, rd, lat);
      chk("rst_readback", rd, 32'h0403_BBAA);

      // Illegal funct3
      access(1'b0, 3'b011, 32'h44, 32'd0, 1'b1, rd, lat);
      chk("ill_latency", 32'(lat), 32'd1);
      access(1'b1, 3'b100, 32'h48, 32'h1234_5678, 1'b1, rd, lat);
      chk("ill_st_rdata", rd, 32'd0);

      for (int i = 0; i < 60; i++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if (i % 4 == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         wd = $urandom;
         access(st, f3, a, wd, 1'($urandom_range(0, 1)), rd, lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
